// File: rtl/ram_pkg.sv
// Shared constants and helpers for the byte-enabled dual-port RAM.
package ram_pkg;

    localparam int BYTE_W = 8;

    function automatic int data_w(input int nbytes);
        return BYTE_W * nbytes;
    endfunction

endpackage

// File: rtl/ram_be_dp_if.sv
// Write/read bus of ram_be_dp, master = requester, slave = RAM.
interface ram_be_dp_if #(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_W     = 10
);
    import ram_pkg::*;

    localparam int DW = data_w(DATA_BYTES);

    logic                  i_we;
    logic [DATA_BYTES-1:0] i_wbe;
    logic [ADDR_W-1:0]     i_waddr;
    logic [DW-1:0]         i_wdata;
    logic                  i_re;
    logic [ADDR_W-1:0]     i_raddr;
    logic                  o_rvalid;
    logic [DW-1:0]         o_rdata;

    modport master (
        output i_we, i_wbe, i_waddr, i_wdata,
        output i_re, i_raddr,
        input  o_rvalid, o_rdata
    );

    modport slave (
        input  i_we, i_wbe, i_waddr, i_wdata,
        input  i_re, i_raddr,
        output o_rvalid, o_rdata
    );

endinterface

// File: rtl/ram_byte_bank.sv
// One byte lane: 8-bit array with synchronous, enable-gated read register.
module ram_byte_bank
    import ram_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [BYTE_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    input  logic              fwd,
    output logic [BYTE_W-1:0] rdata
);

    logic [BYTE_W-1:0] mem_q [2**ADDR_W];
    logic [BYTE_W-1:0] rdata_q;
    logic [BYTE_W-1:0] rdata_d;

    // fwd marks a same-edge collision; only lanes being written take new data
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = (fwd && we) ? wdata : mem_q[raddr];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_be_dp.sv
// Byte-enabled simple dual-port RAM with valid tracking and optional out reg.
// RAM_BYPASS_EN selects write-first forwarding on same-address collisions.
module ram_be_dp
    import ram_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int ADDR_W     = 10,
    parameter int OUT_REG    = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    ram_be_dp_if.slave  bus
);

    localparam int DW = data_w(DATA_BYTES);

    logic          fwd;
    logic          v1_q;
    logic          v1_d;
    logic [DW-1:0] rd1;

`ifdef RAM_BYPASS_EN
    assign fwd = bus.i_re & bus.i_we & (bus.i_raddr == bus.i_waddr);
`else
    assign fwd = 1'b0;
`endif

    for (genvar k = 0; k < DATA_BYTES; k++) begin : g_bank
        ram_byte_bank #(
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (bus.i_we & bus.i_wbe[k] & rst_n),
            .waddr (bus.i_waddr),
            .wdata (bus.i_wdata[k*BYTE_W +: BYTE_W]),
            .re    (bus.i_re),
            .raddr (bus.i_raddr),
            .fwd   (fwd),
            .rdata (rd1[k*BYTE_W +: BYTE_W])
        );
    end

    always_comb begin
        v1_d = bus.i_re;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic          v2_q;
        logic          v2_d;
        logic [DW-1:0] d2_q;
        logic [DW-1:0] d2_d;

        always_comb begin
            v2_d = v1_q;
            d2_d = d2_q;
            if (v1_q) begin
                d2_d = rd1;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v2_q <= 1'b0;
                d2_q <= '0;
            end else begin
                v2_q <= v2_d;
                d2_q <= d2_d;
            end
        end

        assign bus.o_rvalid = v2_q;
        assign bus.o_rdata  = d2_q;
    end else begin : g_noreg
        assign bus.o_rvalid = v1_q;
        assign bus.o_rdata  = rd1;
    end

endmodule

// File: tb/tb_ram_be_dp.sv
// Scoreboard bench: drives latency-1 and latency-2 instances in lockstep.
module tb_ram_be_dp;

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int edge_n  = 0;

    logic [31:0] cur_exp = '0;
    logic [31:0] last [2];
    exp_t q0 [$];
    exp_t q1 [$];

    ram_be_dp_if #(.DATA_BYTES(4), .ADDR_W(4)) if0 ();
    ram_be_dp_if #(.DATA_BYTES(4), .ADDR_W(4)) if1 ();

    assign if1.i_we    = if0.i_we;
    assign if1.i_wbe   = if0.i_wbe;
    assign if1.i_waddr = if0.i_waddr;
    assign if1.i_wdata = if0.i_wdata;
    assign if1.i_re    = if0.i_re;
    assign if1.i_raddr = if0.i_raddr;

    ram_be_dp #(.DATA_BYTES(4), .ADDR_W(4), .OUT_REG(0)) u_dut0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if0.slave)
    );

    ram_be_dp #(.DATA_BYTES(4), .ADDR_W(4), .OUT_REG(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic mon(input int k, input logic v, input logic [31:0] d);
        int   n;
        exp_t e;
        n = (k == 0) ? q0.size() : q1.size();
        e = '{d: '0, due: 0};
        if (n > 0) e = (k == 0) ? q0[0] : q1[0];
        if (v) begin
            if (n == 0) begin
                chk($sformatf("spur%0d", k), {31'b0, v}, 32'd0);
            end else begin
                if (k == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
                chk($sformatf("data%0d", k), d, e.d);
                chk($sformatf("lat%0d", k), edge_n, e.due);
                last[k] = e.d;
            end
        end else begin
            if (n > 0 && e.due <= edge_n) begin
                chk($sformatf("miss%0d", k), {31'b0, v}, 32'd1);
                if (k == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
            end
            chk($sformatf("hold%0d", k), d, last[k]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            last[0] = '0;
            last[1] = '0;
        end else if (if0.i_re) begin
            q0.push_back('{d: cur_exp, due: edge_n});
            q1.push_back('{d: cur_exp, due: edge_n + 1});
        end
        #1;
        mon(0, if0.o_rvalid, if0.o_rdata);
        mon(1, if1.o_rvalid, if1.o_rdata);
    endtask

    task automatic io(input logic we, input logic [3:0] wa,
                      input logic [31:0] wd, input logic [3:0] wbe,
                      input logic re, input logic [3:0] ra,
                      input logic [31:0] exp);
        if0.i_we    = we;
        if0.i_waddr = wa;
        if0.i_wdata = wd;
        if0.i_wbe   = wbe;
        if0.i_re    = re;
        if0.i_raddr = ra;
        cur_exp     = exp;
        tick();
        if0.i_we = 1'b0;
        if0.i_re = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d,
                      input logic [3:0] be);
        io(1'b1, a, d, be, 1'b0, '0, '0);
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] exp);
        io(1'b0, '0, '0, '0, 1'b1, a, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        logic [31:0] col_exp;
        last[0] = '0;
        last[1] = '0;
        if0.i_we    = 1'b0;
        if0.i_wbe   = '0;
        if0.i_waddr = '0;
        if0.i_wdata = '0;
        if0.i_re    = 1'b0;
        if0.i_raddr = '0;

        idle(2);
        chk("rst_v0", {31'b0, if0.o_rvalid}, 32'd0);
        chk("rst_v1", {31'b0, if1.o_rvalid}, 32'd0);
        chk("rst_d1", if1.o_rdata, 32'd0);
        rst_n = 1'b1;
        idle(1);

        wr(4'd5, 32'hAABBCCDD, 4'hF);
        wr(4'd5, 32'h11223344, 4'b0101);
        rd(4'd5, 32'hAA22CC44);
        idle(3);

        for (int i = 0; i < 4; i++) wr(4'(i), 32'(i), 4'hF);
        for (int i = 0; i < 4; i++) rd(4'(i), 32'(i));
        idle(4);

        wr(4'd7, 32'h12345678, 4'hF);
`ifdef RAM_BYPASS_EN
        col_exp = 32'h1234FFFF;
`else
        col_exp = 32'h12345678;
`endif
        io(1'b1, 4'd7, 32'hFFFFFFFF, 4'b0011, 1'b1, 4'd7, col_exp);
        rd(4'd7, 32'h1234FFFF);
        idle(3);

        wr(4'd15, 32'hDEADBEEF, 4'hF);
        wr(4'd0, 32'h0, 4'hF);
        rd(4'd15, 32'hDEADBEEF);
        rd(4'd0, 32'h0);
        wr(4'd15, 32'h0, 4'h0);
        rd(4'd15, 32'hDEADBEEF);
        io(1'b1, 4'd3, 32'h55555555, 4'hF, 1'b1, 4'd15, 32'hDEADBEEF);
        rd(4'd3, 32'h55555555);
        idle(3);

        wr(4'd9, 32'h1, 4'hF);
        rd(4'd9, 32'h1);
        wr(4'd9, 32'h2, 4'hF);
        rd(4'd9, 32'h2);
        idle(3);

        rd(4'd9, 32'h2);
        rst_n = 1'b0;
        wr(4'd5, 32'h0, 4'hF);
        chk("mid_rst_d1", if1.o_rdata, 32'd0);
        rst_n = 1'b1;
        idle(2);
        rd(4'd5, 32'hAA22CC44);
        idle(4);

        chk("drain0", q0.size(), 32'd0);
        chk("drain1", q1.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
